alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  command present on F/A/B/Cin.
REQ-005 in_ready  output  1  block can accept a command this cycle.
REQ-006 F  input  4  opcode.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry/borrow in; used by ADC and SBC only.
REQ-010 out_valid  output  1  result D and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 D  output  WIDTH  result.
REQ-013 flags  output  5  {ill, dz, v, c, z}: illegal opcode, divide-by-zero, signed overflow, carry/borrow/high-half-nonzero, result zero.

Function
REQ-014 Opcodes: 0000 NOT A; 0001 SBC A-B-Cin; 0010 ADC A+B+Cin; 0011 AND; 0100 OR; 0101 XOR; 0110 XNOR; 0111 MUL; 1000 DIV; 1001 SHL A by 1; 1010 SHR A by 1 (logical); 1011 INC; 1100 DEC.
REQ-015 A command is accepted on a rising edge where in_valid && in_ready; F, A, B, Cin are captured on that edge and inputs are ignored afterwards.
REQ-016 FSM states: IDLE, BUSY, DONE; IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting MUL/DIV; BUSY->DONE when the iteration count reaches WIDTH; DONE->IDLE on out_ready.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 Latency: single-cycle op accepted at edge n gives out_valid after edge n+1; MUL/DIV gives out_valid after edge n+WIDTH+1.
REQ-019 D and flags are registered and held stable while out_valid && !out_ready.
REQ-020 ADC/INC: c = carry out of bit WIDTH-1; SBC/DEC: c = borrow; v = two's-complement overflow; v = 0 for all other ops.
REQ-021 MUL is unsigned shift-add, one bit per cycle; D = low WIDTH bits; c = 1 if the high WIDTH bits are nonzero.
REQ-022 DIV is unsigned restoring division, one bit per cycle; D = quotient; the remainder is discarded.
REQ-023 DIV with B == 0 runs the full WIDTH cycles and returns D = all ones, dz = 1, c = 0.
REQ-024 SHL: c = A[WIDTH-1]; SHR: c = A[0]; logic ops and NOT: c = 0.
REQ-025 z = (D == 0) for every op.
REQ-026 Opcodes 1101..1111 complete as single-cycle ops with D = 0, ill = 1, z = 1; all other flags 0.
REQ-027 Wrap-around is modulo 2^WIDTH: INC of all ones gives 0 with c = 1; DEC of 0 gives all ones with c = 1.

Reset
REQ-028 rst asserted at any time, including mid-BUSY, forces state IDLE, D = 0, flags = 0, out_valid = 0, the iteration counter to 0, and aborts any operation in flight without producing a result.
REQ-029 in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-030 Package alu_pkg holds the opcode constants, the FSM state enum and the flag bit indices.
REQ-031 One sub-module, alu_muldiv, holds the iterative shift-add/restoring datapath and its counter; start/done ports connect it to the alu_mc FSM.

Verification (WIDTH=8)
REQ-032 ADC A=8'hFF, B=8'h00, Cin=1 -> out_valid after 1 cycle, D=8'h00, c=1, z=1, v=0.
REQ-033 ADC A=8'h7F, B=8'h01, Cin=0 -> D=8'h80, v=1, c=0; then SBC A=8'h00, B=8'h00, Cin=1 -> D=8'hFF, c=1.
REQ-034 MUL A=8'd20, B=8'd13 -> in_ready low for 9 cycles, D=8'h04 (260 mod 256), c=1; DIV A=8'd200, B=8'd7 -> D=8'd28.
REQ-035 DIV A=8'd5, B=8'd0 -> D=8'hFF, dz=1 after 9 cycles; F=4'b1110 -> D=0, ill=1.
REQ-036 out_ready held low for 5 cycles after DONE -> D/flags stable, in_ready stays low; a new command is accepted only in the cycle after the out_ready handshake.
REQ-037 rst pulsed in cycle 4 of a MUL -> out_valid never asserts for that MUL, outputs are 0, and a following ADC completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for the
// multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOT  = 4'b0000;
  localparam logic [3:0] OP_SBC  = 4'b0001;
  localparam logic [3:0] OP_ADC  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_INC  = 4'b1011;
  localparam logic [3:0] OP_DEC  = 4'b1100;

  // flags vector is {ill, dz, v, c, z}
  localparam int NFLAGS   = 5;
  localparam int FLAG_Z   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_DZ  = 3;
  localparam int FLAG_ILL = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide, one
// bit per cycle, with its own iteration counter.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nz,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               running_q, running_d;
  logic               is_div_q, is_div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  // acc holds the product for MUL and {remainder, quotient} for DIV
  always_comb begin
    running_d = running_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    b_d       = b_q;
    acc_d     = acc_q;
    shifted   = '0;
    trial     = '0;
    done      = running_q && (cnt_q == CW'(WIDTH));
    if (start) begin
      running_d = 1'b1;
      is_div_d  = is_div;
      cnt_d     = '0;
      b_d       = b;
      mcand_d   = {{WIDTH{1'b0}}, a};
      acc_d     = is_div ? {{WIDTH{1'b0}}, a} : '0;
    end else if (done) begin
      running_d = 1'b0;
    end else if (running_q) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        trial   = shifted - {1'b0, b_q};
        if (!trial[WIDTH]) begin
          acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (b_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      b_q       <= '0;
      acc_q     <= '0;
    end else begin
      running_q <= running_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
    end
  end

  assign result = acc_q[WIDTH-1:0];
  assign hi_nz  = !is_div_q && (acc_q[2*WIDTH-1:WIDTH] != '0);
  assign dz     = is_div_q && (b_q == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready command and result handshakes, single-cycle
// ops computed at acceptance, MUL/DIV handed to the iterative datapath.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        F,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  D,
  output logic [NFLAGS-1:0] flags
);

  localparam int M = WIDTH - 1;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    d_q, d_d;
  logic [NFLAGS-1:0]   flags_q, flags_d;
  logic [WIDTH:0]      ext;
  logic [WIDTH-1:0]    alu_res;
  logic [NFLAGS-1:0]   alu_flags;
  logic                start;
  logic                md_done, md_hi_nz, md_dz;
  logic [WIDTH-1:0]    md_result;

  always_comb begin
    ext       = '0;
    alu_res   = '0;
    alu_flags = '0;
    case (F)
      OP_NOT:  alu_res = ~A;
      OP_SBC: begin
        ext     = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};
        alu_res = ext[M:0];
        alu_flags[FLAG_C] = ext[WIDTH];
        alu_flags[FLAG_V] = (A[M] != B[M]) && (ext[M] != A[M]);
      end
      OP_ADC: begin
        ext     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        alu_res = ext[M:0];
        alu_flags[FLAG_C] = ext[WIDTH];
        alu_flags[FLAG_V] = (A[M] == B[M]) && (ext[M] != A[M]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_XNOR: alu_res = ~(A ^ B);
      OP_SHL: begin
        alu_res = {A[M-1:0], 1'b0};
        alu_flags[FLAG_C] = A[M];
      end
      OP_SHR: begin
        alu_res = {1'b0, A[M:1]};
        alu_flags[FLAG_C] = A[0];
      end
      OP_INC: begin
        ext     = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = ext[M:0];
        alu_flags[FLAG_C] = ext[WIDTH];
        alu_flags[FLAG_V] = !A[M] && ext[M];
      end
      OP_DEC: begin
        ext     = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};
        alu_res = ext[M:0];
        alu_flags[FLAG_C] = ext[WIDTH];
        alu_flags[FLAG_V] = A[M] && !ext[M];
      end
      OP_MUL, OP_DIV: alu_res = '0;
      default: alu_flags[FLAG_ILL] = 1'b1;
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
  end

  // Results are captured once, so D/flags hold while the consumer stalls
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    flags_d = flags_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iterative(F)) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DONE;
            d_d     = alu_res;
            flags_d = alu_flags;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_DONE;
          d_d     = md_result;
          flags_d = '0;
          flags_d[FLAG_C]  = md_hi_nz;
          flags_d[FLAG_DZ] = md_dz;
          flags_d[FLAG_Z]  = (md_result == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      flags_q <= flags_d;
    end
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (F == OP_DIV),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result),
    .hi_nz  (md_hi_nz),
    .dz     (md_dz)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign D         = d_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=8: an integer reference model
// pushes expected results into a scoreboard queue when each command is driven.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [3:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [4:0] fl;
    int         busy;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] F;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] D;
  logic [4:0] flags;

  int   total = 0;
  int   bad   = 0;
  exp_t scoreboard[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F         (F),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain integer arithmetic; busy is the number
  // of sampled cycles with in_ready low before out_valid rises.
  function automatic exp_t model(input logic [3:0] f, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
    exp_t e;
    int ai, bi, ci, sa, sbv, r, sr;
    logic c, v, dz, ill;
    ai = int'(a);
    bi = int'(b);
    ci = cin ? 1 : 0;
    sa = int'($signed(a));
    sbv = int'($signed(b));
    r = 0; sr = 0; c = 0; v = 0; dz = 0; ill = 0;
    e.busy = 0;
    case (f)
      4'h0: r = 255 - ai;
      4'h1: begin r = ai - bi - ci; c = (r < 0); sr = sa - sbv - ci; v = (sr < -128) || (sr > 127); end
      4'h2: begin r = ai + bi + ci; c = (r > 255); sr = sa + sbv + ci; v = (sr < -128) || (sr > 127); end
      4'h3: r = ai & bi;
      4'h4: r = ai | bi;
      4'h5: r = ai ^ bi;
      4'h6: r = 255 - (ai ^ bi);
      4'h7: begin r = ai * bi; c = (r > 255); e.busy = W + 1; end
      4'h8: begin
        e.busy = W + 1;
        if (bi == 0) begin r = 255; dz = 1; end
        else r = ai / bi;
      end
      4'h9: begin r = ai * 2; c = (ai > 127); end
      4'hA: begin r = ai / 2; c = (ai % 2 == 1); end
      4'hB: begin r = ai + 1; c = (r > 255); v = (sa == 127); end
      4'hC: begin r = ai - 1; c = (r < 0); v = (sa == -128); end
      default: ill = 1;
    endcase
    e.d  = 8'(r & 255);
    e.fl = {ill, dz, v, c, (e.d == 8'd0)};
    return e;
  endfunction

  // Drives one command, pushes its expectation, then collects the result and
  // holds out_ready low for 'hold' cycles while watching for output changes.
  task automatic run_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input int hold, output logic [7:0] d,
                        output logic [4:0] fl, output int busy, output bit unstable);
    int k;
    d = '0; fl = '0; busy = 0; unstable = 1'b0;
    scoreboard.push_back(model(f, a, b, cin));
    @(negedge clk);
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
      return;
    end
    in_valid = 1'b1; F = f; A = a; B = b; Cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    F = 4'($urandom); A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
    @(negedge clk);
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      if (in_ready === 1'b0) busy++;
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      total++; bad++;
      $display("[TB] FAIL result_timeout out_valid=%b required=1", out_valid);
      return;
    end
    d = D; fl = flags;
    repeat (hold) begin
      @(negedge clk);
      if (D !== d || flags !== fl || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    if (D !== 8'h00) begin bad++; $display("[TB] FAIL reset_D got=%h want=00", D); end
    if (flags !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00000", flags); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_arith();
    vec_t v[7];
    logic [7:0] d; logic [4:0] fl; int busy; bit us; exp_t e;
    v[0] = '{OP_ADC, 8'hFF, 8'h00, 1'b1};
    v[1] = '{OP_ADC, 8'h7F, 8'h01, 1'b0};
    v[2] = '{OP_SBC, 8'h00, 8'h00, 1'b1};
    v[3] = '{OP_SBC, 8'h80, 8'h01, 1'b0};
    v[4] = '{OP_INC, 8'hFF, 8'h12, 1'b1};
    v[5] = '{OP_DEC, 8'h00, 8'h34, 1'b0};
    v[6] = '{OP_DEC, 8'h80, 8'h00, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].cin, 0, d, fl, busy, us);
      e = scoreboard.pop_front();
      total += 3;
      if (d !== e.d) begin bad++; $display("[TB] FAIL arith%0d_D got=%h want=%h", i, d, e.d); end
      if (fl !== e.fl) begin bad++; $display("[TB] FAIL arith%0d_flags got=%b want=%b", i, fl, e.fl); end
      if (busy !== e.busy) begin bad++; $display("[TB] FAIL arith%0d_latency got=%0d want=%0d", i, busy, e.busy); end
    end
  endtask

  task automatic test_logic_shift();
    vec_t v[8];
    logic [7:0] d; logic [4:0] fl; int busy; bit us; exp_t e;
    v[0] = '{OP_NOT,  8'hA5, 8'h00, 1'b1};
    v[1] = '{OP_AND,  8'hF0, 8'h3C, 1'b1};
    v[2] = '{OP_OR,   8'h81, 8'h18, 1'b0};
    v[3] = '{OP_XOR,  8'h5A, 8'h5A, 1'b1};
    v[4] = '{OP_XNOR, 8'h5A, 8'h5A, 1'b0};
    v[5] = '{OP_SHL,  8'h81, 8'h00, 1'b0};
    v[6] = '{OP_SHR,  8'h01, 8'h00, 1'b1};
    v[7] = '{OP_SHR,  8'hC6, 8'hFF, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].cin, 0, d, fl, busy, us);
      e = scoreboard.pop_front();
      total += 2;
      if (d !== e.d) begin bad++; $display("[TB] FAIL logic%0d_D got=%h want=%h", i, d, e.d); end
      if (fl !== e.fl) begin bad++; $display("[TB] FAIL logic%0d_flags got=%b want=%b", i, fl, e.fl); end
    end
  endtask

  task automatic test_mul_div();
    vec_t v[6];
    logic [7:0] d; logic [4:0] fl; int busy; bit us; exp_t e;
    v[0] = '{OP_MUL, 8'd20,  8'd13, 1'b0};
    v[1] = '{OP_DIV, 8'd200, 8'd7,  1'b1};
    v[2] = '{OP_DIV, 8'd5,   8'd0,  1'b0};
    v[3] = '{OP_MUL, 8'd15,  8'd17, 1'b1};
    v[4] = '{OP_DIV, 8'd255, 8'd1,  1'b0};
    v[5] = '{OP_MUL, 8'd0,   8'd99, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, v[i].cin, 0, d, fl, busy, us);
      e = scoreboard.pop_front();
      total += 3;
      if (d !== e.d) begin bad++; $display("[TB] FAIL muldiv%0d_D got=%h want=%h", i, d, e.d); end
      if (fl !== e.fl) begin bad++; $display("[TB] FAIL muldiv%0d_flags got=%b want=%b", i, fl, e.fl); end
      if (busy !== e.busy) begin bad++; $display("[TB] FAIL muldiv%0d_busy got=%0d want=%0d", i, busy, e.busy); end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] d; logic [4:0] fl; int busy; bit us; exp_t e;
    for (int i = 13; i < 16; i++) begin
      run_op(4'(i), 8'hFF, 8'hFF, 1'b1, 0, d, fl, busy, us);
      e = scoreboard.pop_front();
      total += 2;
      if (d !== e.d) begin bad++; $display("[TB] FAIL illegal%0d_D got=%h want=%h", i, d, e.d); end
      if (fl !== e.fl) begin bad++; $display("[TB] FAIL illegal%0d_flags got=%b want=%b", i, fl, e.fl); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic [4:0] fl; int busy; bit us; exp_t e;
    run_op(OP_MUL, 8'd20, 8'd13, 1'b0, 5, d, fl, busy, us);
    e = scoreboard.pop_front();
    total += 4;
    if (d !== e.d) begin bad++; $display("[TB] FAIL stall_D got=%h want=%h", d, e.d); end
    if (fl !== e.fl) begin bad++; $display("[TB] FAIL stall_flags got=%b want=%b", fl, e.fl); end
    if (us !== 1'b0) begin bad++; $display("[TB] FAIL stall_hold changed=%b want=0", us); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_release in_ready=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid_mul();
    logic [7:0] d; logic [4:0] fl; int busy, seen; bit us; exp_t e;
    @(negedge clk);
    in_valid = 1'b1; F = OP_MUL; A = 8'd20; B = 8'd13; Cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_out_valid got=%b want=0", out_valid); end
    if (D !== 8'h00) begin bad++; $display("[TB] FAIL abort_D got=%h want=00", D); end
    if (flags !== 5'b0) begin bad++; $display("[TB] FAIL abort_flags got=%b want=00000", flags); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_ready got=%b want=1", in_ready); end
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("[TB] FAIL abort_no_result valid_cycles=%0d want=0", seen); end
    run_op(OP_ADC, 8'h10, 8'h20, 1'b1, 0, d, fl, busy, us);
    e = scoreboard.pop_front();
    total += 2;
    if (d !== e.d) begin bad++; $display("[TB] FAIL post_abort_D got=%h want=%h", d, e.d); end
    if (fl !== e.fl) begin bad++; $display("[TB] FAIL post_abort_flags got=%b want=%b", fl, e.fl); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic [4:0] fl; int busy; bit us; exp_t e;
    logic [3:0] f;
    for (int i = 0; i < 24; i++) begin
      f = 4'($urandom_range(0, 15));
      run_op(f, 8'($urandom), 8'($urandom), 1'($urandom), 0, d, fl, busy, us);
      e = scoreboard.pop_front();
      total += 3;
      if (d !== e.d) begin bad++; $display("[TB] FAIL b2b%0d_D op=%h got=%h want=%h", i, f, d, e.d); end
      if (fl !== e.fl) begin bad++; $display("[TB] FAIL b2b%0d_flags op=%h got=%b want=%b", i, f, fl, e.fl); end
      if (busy !== e.busy) begin bad++; $display("[TB] FAIL b2b%0d_busy op=%h got=%0d want=%0d", i, f, busy, e.busy); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    F = '0; A = '0; B = '0; Cin = 1'b0;
    test_reset();
    test_arith();
    test_logic_shift();
    test_mul_div();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
